// File: rtl/memory_access.sv
// Memory-stage access unit: drives a req/ack data-memory port,
// stalls the pipeline while an access is outstanding, resolves CBZ.
module memory_access #(
   parameter int N       = 64,
   parameter int TIMEOUT = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         valid_M,
   input  logic         memRead_M,
   input  logic         memWrite_M,
   input  logic         Branch_M,
   input  logic         zero_M,
   input  logic [N-1:0] aluResult_M,
   input  logic [N-1:0] writeData_M,
   input  logic [N-1:0] PCBranch_M,
   output logic         dm_req,
   output logic         dm_we,
   output logic [N-1:0] dm_addr,
   output logic [N-1:0] dm_wdata,
   input  logic         dm_ack,
   input  logic [N-1:0] dm_rdata,
   output logic [N-1:0] readData_M,
   output logic         PCSrc_M,
   output logic [N-1:0] PCBranch_out,
   output logic         stall_M,
   output logic         mem_err
);

   localparam int CW = $clog2(TIMEOUT);
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic          is_mem;
   logic          aligned;

   assign is_mem  = valid_M & (memRead_M | memWrite_M);
   assign aligned = (aluResult_M[2:0] == 3'b000);

   // Access FSM; every dm_* output and the load result are flops.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         cnt        <= '0;
         dm_req     <= 1'b0;
         dm_we      <= 1'b0;
         dm_addr    <= '0;
         dm_wdata   <= '0;
         readData_M <= '0;
         mem_err    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (is_mem) begin
                  if (aligned) begin
                     dm_addr  <= aluResult_M;
                     dm_wdata <= writeData_M;
                     dm_we    <= memWrite_M;
                     dm_req   <= 1'b1;
                     cnt      <= '0;
                     state    <= BUSY;
                  end else begin
                     mem_err    <= 1'b1;
                     readData_M <= '0;
                     state      <= DONE;
                  end
               end
            end
            BUSY: begin
               if (dm_ack) begin
                  dm_req <= 1'b0;
                  if (!dm_we)
                     readData_M <= dm_rdata;
                  state <= DONE;
               end else if (cnt == LAST) begin
                  dm_req     <= 1'b0;
                  mem_err    <= 1'b1;
                  readData_M <= '0;
                  state      <= DONE;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               dm_req <= 1'b0;
               state  <= IDLE;
            end
         endcase
      end
   end

   // Hold upstream while a memory op waits to issue or is in flight.
   always_comb begin
      stall_M = 1'b0;
      if (state == BUSY)
         stall_M = 1'b1;
      else if (state == IDLE)
         stall_M = is_mem;
   end

   assign PCSrc_M      = valid_M & Branch_M & zero_M;
   assign PCBranch_out = PCBranch_M;

endmodule

// File: tb/tb_memory_access.sv
// Scoreboard bench for memory_access: driver pushes per-cycle
// expectations, monitor pops and compares on the falling edge.
module tb_memory_access;

   localparam int N = 64;

   typedef struct {
      int          id;
      logic        stall;
      logic        req;
      logic        we;
      logic        err;
      logic        pcsrc;
      logic [63:0] addr;
      logic [63:0] wdata;
      logic [63:0] rd;
      logic [63:0] pcb;
   } exp_t;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic         valid_M = 1'b0;
   logic         memRead_M = 1'b0;
   logic         memWrite_M = 1'b0;
   logic         Branch_M = 1'b0;
   logic         zero_M = 1'b0;
   logic [N-1:0] aluResult_M = '0;
   logic [N-1:0] writeData_M = '0;
   logic [N-1:0] PCBranch_M = '0;
   logic         dm_req;
   logic         dm_we;
   logic [N-1:0] dm_addr;
   logic [N-1:0] dm_wdata;
   logic         dm_ack = 1'b0;
   logic [N-1:0] dm_rdata = '0;
   logic [N-1:0] readData_M;
   logic         PCSrc_M;
   logic [N-1:0] PCBranch_out;
   logic         stall_M;
   logic         mem_err;

   memory_access #(.N(N), .TIMEOUT(16)) dut (
      .clk          (clk),
      .reset        (reset),
      .valid_M      (valid_M),
      .memRead_M    (memRead_M),
      .memWrite_M   (memWrite_M),
      .Branch_M     (Branch_M),
      .zero_M       (zero_M),
      .aluResult_M  (aluResult_M),
      .writeData_M  (writeData_M),
      .PCBranch_M   (PCBranch_M),
      .dm_req       (dm_req),
      .dm_we        (dm_we),
      .dm_addr      (dm_addr),
      .dm_wdata     (dm_wdata),
      .dm_ack       (dm_ack),
      .dm_rdata     (dm_rdata),
      .readData_M   (readData_M),
      .PCSrc_M      (PCSrc_M),
      .PCBranch_out (PCBranch_out),
      .stall_M      (stall_M),
      .mem_err      (mem_err)
   );

   always #5 clk = ~clk;

   exp_t q[$];
   int   ncmp = 0;
   int   nbad = 0;
   int   cyc_id = 0;

   logic        s_rst = 1'b0;
   logic        s_v, s_rd, s_wr, s_br, s_z, s_ack;
   logic [63:0] s_a, s_wd, s_rdat, s_pcb;

   task automatic chk(string n, int id, logic [63:0] act, logic [63:0] exp);
      ncmp++;
      if (act !== exp) begin
         nbad++;
         $display("FAIL %s cyc %0d: got %0h expected %0h", n, id, act, exp);
      end
   endtask

   // Monitor: one expectation per cycle, compared mid-cycle.
   always @(negedge clk) begin
      if (q.size() != 0) begin
         exp_t e;
         e = q.pop_front();
         chk("stall_M", e.id, 64'(stall_M), 64'(e.stall));
         chk("dm_req", e.id, 64'(dm_req), 64'(e.req));
         chk("dm_we", e.id, 64'(dm_we), 64'(e.we));
         chk("dm_addr", e.id, dm_addr, e.addr);
         chk("dm_wdata", e.id, dm_wdata, e.wdata);
         chk("readData_M", e.id, readData_M, e.rd);
         chk("mem_err", e.id, 64'(mem_err), 64'(e.err));
         chk("PCSrc_M", e.id, 64'(PCSrc_M), 64'(e.pcsrc));
         chk("PCBranch_out", e.id, PCBranch_out, e.pcb);
      end
   end

   task automatic stg(logic v, logic rd, logic wr, logic br, logic z,
                      logic [63:0] a, logic [63:0] wd,
                      logic ack, logic [63:0] rdat);
      s_v = v; s_rd = rd; s_wr = wr; s_br = br; s_z = z;
      s_a = a; s_wd = wd; s_ack = ack; s_rdat = rdat;
      s_pcb = 64'hFEED_0000_0000_0000 | a;
   endtask

   task automatic idle();
      stg(0, 0, 0, 0, 0, 64'h0, 64'h0, 0, 64'h0);
   endtask

   // Drive staged inputs just after the edge, push the expected view.
   task automatic step(logic es, logic eq, logic ewe,
                       logic [63:0] ea, logic [63:0] ewd,
                       logic [63:0] erd, logic eerr, logic epc);
      exp_t e;
      @(posedge clk);
      #1;
      reset       = s_rst;
      valid_M     = s_v;
      memRead_M   = s_rd;
      memWrite_M  = s_wr;
      Branch_M    = s_br;
      zero_M      = s_z;
      aluResult_M = s_a;
      writeData_M = s_wd;
      PCBranch_M  = s_pcb;
      dm_ack      = s_ack;
      dm_rdata    = s_rdat;
      cyc_id++;
      e.id = cyc_id; e.stall = es; e.req = eq; e.we = ewe;
      e.addr = ea; e.wdata = ewd; e.rd = erd; e.err = eerr;
      e.pcsrc = epc; e.pcb = s_pcb;
      q.push_back(e);
   endtask

   initial begin
      idle();
      // reset state
      s_rst = 1'b0;
      step(0, 0, 0, 0, 0, 0, 0, 0);
      s_rst = 1'b1;
      step(0, 0, 0, 0, 0, 0, 0, 0);

      // load 0x40, ack in first BUSY cycle
      stg(1, 1, 0, 0, 0, 64'h40, 64'h0, 0, 64'h0);
      step(1, 0, 0, 0, 0, 0, 0, 0);
      stg(1, 1, 0, 0, 0, 64'h40, 64'h0, 1, 64'hDEAD_BEEF);
      step(1, 1, 0, 64'h40, 0, 0, 0, 0);
      stg(1, 1, 0, 0, 0, 64'h40, 64'h0, 0, 64'h0);
      step(0, 0, 0, 64'h40, 0, 64'hDEAD_BEEF, 0, 0);
      idle();
      step(0, 0, 0, 64'h40, 0, 64'hDEAD_BEEF, 0, 0);

      // store 0x80 <- 0x1234, ack after 4 extra cycles
      stg(1, 0, 1, 0, 0, 64'h80, 64'h1234, 0, 64'h0);
      step(1, 0, 0, 64'h40, 0, 64'hDEAD_BEEF, 0, 0);
      repeat (4) step(1, 1, 1, 64'h80, 64'h1234, 64'hDEAD_BEEF, 0, 0);
      stg(1, 0, 1, 0, 0, 64'h80, 64'h1234, 1, 64'hFFFF);
      step(1, 1, 1, 64'h80, 64'h1234, 64'hDEAD_BEEF, 0, 0);
      idle();
      step(0, 0, 1, 64'h80, 64'h1234, 64'hDEAD_BEEF, 0, 0);
      step(0, 0, 1, 64'h80, 64'h1234, 64'hDEAD_BEEF, 0, 0);

      // branches never stall; PCSrc only when valid & taken
      stg(1, 0, 0, 1, 1, 64'h500, 64'h0, 0, 64'h0);
      step(0, 0, 1, 64'h80, 64'h1234, 64'hDEAD_BEEF, 0, 1);
      stg(1, 0, 0, 1, 0, 64'h504, 64'h0, 0, 64'h0);
      step(0, 0, 1, 64'h80, 64'h1234, 64'hDEAD_BEEF, 0, 0);
      stg(0, 0, 0, 1, 1, 64'h508, 64'h0, 0, 64'h0);
      step(0, 0, 1, 64'h80, 64'h1234, 64'hDEAD_BEEF, 0, 0);

      // read+write together acts as a store
      stg(1, 1, 1, 0, 0, 64'hC0, 64'h5A5A, 0, 64'h0);
      step(1, 0, 1, 64'h80, 64'h1234, 64'hDEAD_BEEF, 0, 0);
      stg(1, 1, 1, 0, 0, 64'hC0, 64'h5A5A, 1, 64'h77);
      step(1, 1, 1, 64'hC0, 64'h5A5A, 64'hDEAD_BEEF, 0, 0);
      idle();
      step(0, 0, 1, 64'hC0, 64'h5A5A, 64'hDEAD_BEEF, 0, 0);
      step(0, 0, 1, 64'hC0, 64'h5A5A, 64'hDEAD_BEEF, 0, 0);

      // timeout: 16 BUSY cycles with no ack
      stg(1, 1, 0, 0, 0, 64'h100, 64'hABC, 0, 64'h0);
      step(1, 0, 1, 64'hC0, 64'h5A5A, 64'hDEAD_BEEF, 0, 0);
      repeat (16) step(1, 1, 0, 64'h100, 64'hABC, 64'hDEAD_BEEF, 0, 0);
      idle();
      step(0, 0, 0, 64'h100, 64'hABC, 64'h0, 1, 0);
      step(0, 0, 0, 64'h100, 64'hABC, 64'h0, 1, 0);

      // reset clears sticky error; then misaligned load
      s_rst = 1'b0;
      step(0, 0, 0, 0, 0, 0, 0, 0);
      s_rst = 1'b1;
      stg(1, 1, 0, 0, 0, 64'h8, 64'h0, 0, 64'h0);
      step(1, 0, 0, 0, 0, 0, 0, 0);
      stg(1, 1, 0, 0, 0, 64'h8, 64'h0, 1, 64'h55AA);
      step(1, 1, 0, 64'h8, 0, 0, 0, 0);
      idle();
      step(0, 0, 0, 64'h8, 0, 64'h55AA, 0, 0);
      stg(1, 1, 0, 0, 0, 64'h43, 64'h0, 0, 64'h0);
      step(1, 0, 0, 64'h8, 0, 64'h55AA, 0, 0);
      idle();
      step(0, 0, 0, 64'h8, 0, 64'h0, 1, 0);
      step(0, 0, 0, 64'h8, 0, 64'h0, 1, 0);

      // reset in the 2nd BUSY cycle of a load
      s_rst = 1'b0;
      step(0, 0, 0, 0, 0, 0, 0, 0);
      s_rst = 1'b1;
      stg(1, 1, 0, 0, 0, 64'h200, 64'h0, 0, 64'h0);
      step(1, 0, 0, 0, 0, 0, 0, 0);
      step(1, 1, 0, 64'h200, 0, 0, 0, 0);
      s_rst = 1'b0;
      step(1, 0, 0, 0, 0, 0, 0, 0);
      stg(0, 0, 0, 0, 0, 64'h0, 64'h0, 1, 64'h999);
      step(0, 0, 0, 0, 0, 0, 0, 0);
      s_rst = 1'b1;
      step(0, 0, 0, 0, 0, 0, 0, 0);
      idle();
      step(0, 0, 0, 0, 0, 0, 0, 0);
      stg(1, 1, 0, 0, 0, 64'h18, 64'h0, 0, 64'h0);
      step(1, 0, 0, 0, 0, 0, 0, 0);
      stg(1, 1, 0, 0, 0, 64'h18, 64'h0, 1, 64'hCAFE);
      step(1, 1, 0, 64'h18, 0, 0, 0, 0);
      idle();
      step(0, 0, 0, 64'h18, 0, 64'hCAFE, 0, 0);

      @(negedge clk);
      #1;
      ncmp++;
      if (q.size() != 0) begin
         nbad++;
         $display("FAIL drain: got %0d pending expected 0", q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
      $finish;
   end

endmodule
